// File: rtl/wave_measure.sv
// Per-channel waveform measurement: windowed max/min/peak-to-peak, hysteretic
// rising-edge period measurement, and a clamped 0-9999 display value.
module wave_measure #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned WINDOW_LOG2 = 10,
  parameter int unsigned HYST        = 64,
  parameter int unsigned PERIOD_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_en,
  input  logic                hold,
  input  logic [DATA_W-1:0]   data,
  input  logic [1:0]          mode,
  output logic [13:0]         number,
  output logic                new_value,
  output logic [DATA_W-1:0]   vpp,
  output logic [DATA_W-1:0]   vmax,
  output logic [DATA_W-1:0]   vmin,
  output logic [PERIOD_W-1:0] period
);

  typedef enum logic {WAIT_LOW, WAIT_HIGH} state_t;

  localparam logic [DATA_W-1:0]   LP_FULL    = '1;
  localparam logic [DATA_W-1:0]   LP_MID_RST = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]   LP_HYST    = DATA_W'(HYST);
  localparam logic [PERIOD_W-1:0] LP_PMAX    = '1;
  localparam logic [PERIOD_W-1:0] LP_PMAX_M1 = LP_PMAX - 1'b1;
  localparam logic [31:0]         LP_CLAMP   = 32'd9999;

  state_t                  r_state;
  logic [WINDOW_LOG2-1:0]  r_win_cnt;
  logic [DATA_W-1:0]       r_run_max;
  logic [DATA_W-1:0]       r_run_min;
  logic [DATA_W-1:0]       r_mid;
  logic [DATA_W-1:0]       r_vmax;
  logic [DATA_W-1:0]       r_vmin;
  logic [DATA_W-1:0]       r_vpp;
  logic [PERIOD_W-1:0]     r_pcnt;
  logic [PERIOD_W-1:0]     r_period;
  logic                    r_have_edge;
  logic                    r_win_done;
  logic                    r_new_value;
  logic [13:0]             r_number;

  logic                    w_accept;
  logic                    w_win_end;
  logic                    w_rise;
  logic [DATA_W-1:0]       w_nmax;
  logic [DATA_W-1:0]       w_nmin;
  logic [DATA_W:0]         w_mid_sum;
  logic [DATA_W:0]         w_hi_sum;
  logic [DATA_W-1:0]       w_thr_hi;
  logic [DATA_W-1:0]       w_thr_lo;
  logic [31:0]             w_sel;
  logic [13:0]             w_number;

  assign w_accept  = sample_en & ~hold;
  assign w_win_end = w_accept && (r_win_cnt == '1);

  // Running extremes start at the opposite rails, so the first sample overwrites both
  assign w_nmax    = (data > r_run_max) ? data : r_run_max;
  assign w_nmin    = (data < r_run_min) ? data : r_run_min;
  assign w_mid_sum = {1'b0, w_nmax} + {1'b0, w_nmin};

  assign w_hi_sum  = {1'b0, r_mid} + {1'b0, LP_HYST};
  assign w_thr_hi  = w_hi_sum[DATA_W] ? LP_FULL : w_hi_sum[DATA_W-1:0];
  assign w_thr_lo  = (r_mid < LP_HYST) ? '0 : (r_mid - LP_HYST);

  assign w_rise    = w_accept && (r_state == WAIT_HIGH) && (data >= w_thr_hi);

  always_comb begin
    w_sel = '0;
    case (mode)
      2'd0:    w_sel = 32'(r_vpp);
      2'd1:    w_sel = 32'(r_vmax);
      2'd2:    w_sel = 32'(r_vmin);
      default: w_sel = 32'(r_period);
    endcase
    w_number = (w_sel > LP_CLAMP) ? 14'd9999 : w_sel[13:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= WAIT_LOW;
      r_win_cnt   <= '0;
      r_run_max   <= '0;
      r_run_min   <= LP_FULL;
      r_mid       <= LP_MID_RST;
      r_vmax      <= '0;
      r_vmin      <= '0;
      r_vpp       <= '0;
      r_pcnt      <= '0;
      r_period    <= '0;
      r_have_edge <= 1'b0;
      r_win_done  <= 1'b0;
      r_new_value <= 1'b0;
      r_number    <= '0;
    end else begin
      r_win_done  <= w_win_end;
      r_new_value <= r_win_done;
      r_number    <= w_number;

      if (w_accept) begin
        r_win_cnt <= r_win_cnt + 1'b1;

        if (w_win_end) begin
          r_vmax    <= w_nmax;
          r_vmin    <= w_nmin;
          r_vpp     <= w_nmax - w_nmin;
          r_mid     <= w_mid_sum[DATA_W:1];
          r_run_max <= '0;
          r_run_min <= LP_FULL;
        end else begin
          r_run_max <= w_nmax;
          r_run_min <= w_nmin;
        end

        case (r_state)
          WAIT_LOW:  if (data < w_thr_lo) r_state <= WAIT_HIGH;
          WAIT_HIGH: if (w_rise)          r_state <= WAIT_LOW;
          default:                        r_state <= WAIT_LOW;
        endcase

        // Timeout fires once, on the sample that brings pcnt to its ceiling
        if (w_rise) begin
          if (r_have_edge) r_period <= r_pcnt + 1'b1;
          r_pcnt      <= '0;
          r_have_edge <= 1'b1;
        end else if (r_pcnt != LP_PMAX) begin
          r_pcnt <= r_pcnt + 1'b1;
          if (r_pcnt == LP_PMAX_M1) begin
            r_period    <= LP_PMAX;
            r_have_edge <= 1'b0;
          end
        end
      end
    end
  end

  assign number    = r_number;
  assign new_value = r_new_value;
  assign vpp       = r_vpp;
  assign vmax      = r_vmax;
  assign vmin      = r_vmin;
  assign period    = r_period;

endmodule
